mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter for instruction fetch and data access.
// Alternates grants under contention and times out hung transfers.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, I_WAIT, D_WAIT, I_DONE, D_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        drop_q, drop_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        berr_q, berr_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mv_q, mv_d;
  logic        mwe_q, mwe_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [3:0]  mwstrb_q, mwstrb_d;
  logic        tmo;
  logic        done;
  logic [31:0] rdat;

  // last_q: 0 = fetch served last, 1 = data served last
  assign tmo  = ~m_ready & (wdog_q == 8'd254);
  assign done = m_ready | tmo;
  assign rdat = m_ready ? m_rdata : 32'd0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    drop_d     = drop_q;
    wdog_d     = wdog_q;
    berr_d     = berr_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mv_d       = mv_q;
    mwe_d      = mwe_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    mwstrb_d   = mwstrb_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!if_req || !last_q)) begin
          state_d  = D_WAIT;
          mv_d     = 1'b1;
          mwe_d    = d_we;
          maddr_d  = d_addr;
          mwdata_d = d_wdata;
          mwstrb_d = d_we ? d_wstrb : 4'd0;
          wdog_d   = 8'd0;
        end else if (if_req) begin
          state_d  = I_WAIT;
          mv_d     = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = if_addr;
          mwdata_d = 32'd0;
          mwstrb_d = 4'd0;
          wdog_d   = 8'd0;
          drop_d   = flush;
        end
      end
      I_WAIT: begin
        if (done) begin
          mv_d = 1'b0;
          if (tmo) berr_d = 1'b1;
          // a redirected fetch still drains the port but is never delivered
          if (drop_q || flush) begin
            state_d = IDLE;
            drop_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d    = I_DONE;
            if_rdata_d = rdat;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (flush) drop_d = 1'b1;
        end
      end
      D_WAIT: begin
        if (done) begin
          mv_d    = 1'b0;
          state_d = D_DONE;
          if (tmo) berr_d = 1'b1;
          if (!mwe_q) d_rdata_d = rdat;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      I_DONE: begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      D_DONE: begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      wdog_q     <= 8'd0;
      berr_q     <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      mv_q       <= 1'b0;
      mwe_q      <= 1'b0;
      maddr_q    <= 32'd0;
      mwdata_q   <= 32'd0;
      mwstrb_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      wdog_q     <= wdog_d;
      berr_q     <= berr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mv_q       <= mv_d;
      mwe_q      <= mwe_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      mwstrb_q   <= mwstrb_d;
    end
  end

  assign if_stall = if_req & (state_q != I_DONE);
  assign d_stall  = d_req & (state_q != D_DONE);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_valid  = mv_q;
  assign m_we     = mwe_q;
  assign m_addr   = maddr_q;
  assign m_wdata  = mwdata_q;
  assign m_wstrb  = mwstrb_q;
  assign bus_err  = berr_q;

endmodule
